maxpool_rd: RTL
===============

MAXPOOL_RD -- requirements
Module: maxpool_rd

Interface
REQ-001 SHALL have parameters: IMG_W, 64, source image width/height in pixels; SRC0_SEL, 3'd1, layer-0 kernel-0 bank; SRC1_SEL, 3'd2, layer-0 kernel-1 bank; DST0_SEL, 3'd3, pooled kernel-0 bank; DST1_SEL, 3'd4, pooled kernel-1 bank.
REQ-002 SHALL have ports: clk in 1 clock; reset in 1 synchronous active-high reset; start in 1 begin-pooling pulse; busy out 1 operation in progress; done out 1 one-cycle completion pulse.
REQ-003 SHALL have ports: crd out 1 read strobe; caddr_rd out 12 read address; cdata_rd in 20 read data; cwr out 1 write strobe; caddr_wr out 12 write address; cdata_wr out 20 write data; csel out 3 bank select.
REQ-004 SHALL use one clock (clk); reset SHALL be synchronous and active-high.

Function
REQ-005 SHALL read the two 64x64 layer-0 maps written by the convolution stage, apply 2x2 max-pooling with stride 2, and write two 32x32 maps.
REQ-006 SHALL process bank SRC0_SEL into DST0_SEL fully, then SRC1_SEL into DST1_SEL.
REQ-007 SHALL traverse outputs raster order: r 0..31 outer, c 0..31 inner.
REQ-008 For output (r,c) SHALL read k=0..3 at row 2r+k[1], col 2c+k[0], caddr_rd = row*64+col.
REQ-009 SHALL write result at caddr_wr = r*32+c.
REQ-010 Memory read protocol: crd and caddr_rd presented in cycle t; cdata_rd valid in cycle t+1, sampled at end of t+1.
REQ-011 Memory write protocol: cwr, caddr_wr, cdata_wr, csel valid together for exactly one cycle per write.
REQ-012 States: IDLE, RD (4 cycles, k=0..3, crd=1), WT (collect k=3 data, crd=0), WR (cwr=1), DONE.
REQ-013 Transitions: IDLE->RD on start; RD->WT after k=3; WT->WR; WR->RD if outputs remain; WR->RD with bank switch after (31,31) of bank 0; WR->DONE after (31,31) of bank 1; DONE->IDLE.
REQ-014 Per-output latency SHALL be 6 cycles; full operation 2*1024*6 = 12288 cycles from first RD cycle to DONE.
REQ-015 Max SHALL be an unsigned 20-bit compare; first sample initialises the running max; ties keep the held value.
REQ-016 csel SHALL equal source bank during RD/WT, destination bank during WR, 3'd0 in IDLE/DONE.
REQ-017 busy SHALL rise the cycle after start is accepted and fall in the cycle DONE is entered; done SHALL be high only in DONE.
REQ-018 start SHALL be accepted only in IDLE; start while busy SHALL be ignored.
REQ-019 crd and cwr SHALL never be high in the same cycle.

Reset
REQ-020 On reset: state IDLE; busy=0, done=0, crd=0, cwr=0, csel=0, caddr_rd=0, caddr_wr=0, cdata_wr=0; counters and running max cleared.
REQ-021 Reset asserted mid-operation SHALL abort in the next cycle with no further crd/cwr; no partial write completes.
REQ-022 After reset, a new start SHALL restart from bank 0, output (0,0).

Structure
REQ-023 A shared package SHALL hold bank-select constants (SRC0_SEL..DST1_SEL), IMG_W, the state enumeration, and the 20-bit data width.
REQ-024 One sub-module, maxpool_cmp4 (running-max register with init/update controls), is natural; address generation and FSM stay in the top.

Verification
REQ-025 Reset then start; memory model bank1 pixel(y,x)=y*64+x -> first write caddr_wr=0, cdata_wr=65, csel=3; write (31,31) caddr_wr=1023, cdata_wr=4095.
REQ-026 Bank 2 all 20'h00000 except pixel (1,1)=20'hFFFFF -> DST1 address 0 written 20'hFFFFF, all others 0.
REQ-027 Timing check: crd high cycles 1-4 after start-accept (addresses 0,1,64,65), cwr high cycle 6; done pulses exactly once at cycle 12289 relative to start-accept; busy low thereafter.
REQ-028 Start pulsed at cycle 500 while busy -> no restart, write sequence unchanged, total 2048 writes.
REQ-029 Reset asserted at cycle 3000 -> next cycle crd=0, cwr=0, busy=0, csel=0; subsequent start yields first write caddr_wr=0, csel=3.
REQ-030 Tie case: 2x2 block all 20'h00123 -> output 20'h00123; bench checks no cycle has crd and cwr both high.

Source files
------------

// File: rtl/maxpool_rd_pkg.sv
// rtl/maxpool_rd_pkg.sv - shared constants and FSM state type for the max-pool reader
package maxpool_rd_pkg;

    localparam int IMG_W  = 64;
    localparam int DATA_W = 20;
    localparam int ADDR_W = 12;
    localparam int SEL_W  = 3;

    localparam logic [SEL_W-1:0] SRC0_SEL = 3'd1;
    localparam logic [SEL_W-1:0] SRC1_SEL = 3'd2;
    localparam logic [SEL_W-1:0] DST0_SEL = 3'd3;
    localparam logic [SEL_W-1:0] DST1_SEL = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_WT,
        ST_WR,
        ST_DONE
    } state_t;

endpackage

// File: rtl/maxpool_cmp4.sv
// rtl/maxpool_cmp4.sv - running-max register; init loads the first sample, update keeps the larger
module maxpool_cmp4
    import maxpool_rd_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              i_init,
    input  logic              i_upd,
    input  logic [DATA_W-1:0] i_data,
    output logic [DATA_W-1:0] o_max
);

    logic [DATA_W-1:0] r_max;

    // Strict greater-than so a tie keeps the held value
    always_ff @(posedge clk) begin
        if (reset) begin
            r_max <= '0;
        end else if (i_init) begin
            r_max <= i_data;
        end else if (i_upd && (i_data > r_max)) begin
            r_max <= i_data;
        end
    end

    assign o_max = r_max;

endmodule

// File: rtl/maxpool_rd.sv
// rtl/maxpool_rd.sv - 2x2 stride-2 max-pooling of two 64x64 banks into two 32x32 banks
module maxpool_rd
    import maxpool_rd_pkg::state_t, maxpool_rd_pkg::ST_IDLE, maxpool_rd_pkg::ST_RD,
           maxpool_rd_pkg::ST_WT, maxpool_rd_pkg::ST_WR, maxpool_rd_pkg::ST_DONE,
           maxpool_rd_pkg::DATA_W, maxpool_rd_pkg::ADDR_W, maxpool_rd_pkg::SEL_W;
#(
    parameter int               IMG_W    = maxpool_rd_pkg::IMG_W,
    parameter logic [SEL_W-1:0] SRC0_SEL = maxpool_rd_pkg::SRC0_SEL,
    parameter logic [SEL_W-1:0] SRC1_SEL = maxpool_rd_pkg::SRC1_SEL,
    parameter logic [SEL_W-1:0] DST0_SEL = maxpool_rd_pkg::DST0_SEL,
    parameter logic [SEL_W-1:0] DST1_SEL = maxpool_rd_pkg::DST1_SEL
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              crd,
    output logic [ADDR_W-1:0] caddr_rd,
    input  logic [DATA_W-1:0] cdata_rd,
    output logic              cwr,
    output logic [ADDR_W-1:0] caddr_wr,
    output logic [DATA_W-1:0] cdata_wr,
    output logic [SEL_W-1:0]  csel
);

    localparam int            OUT_W = IMG_W / 2;
    localparam int            CW    = $clog2(OUT_W);
    localparam logic [CW-1:0] LAST  = CW'(OUT_W - 1);

    state_t            r_state;
    state_t            w_next;
    logic [CW-1:0]     r_row;
    logic [CW-1:0]     r_col;
    logic [1:0]        r_k;
    logic              r_bank;
    logic              r_vld;
    logic              r_first;
    logic              w_last_pix;
    logic [ADDR_W-1:0] w_row_rd;
    logic [ADDR_W-1:0] w_col_rd;
    logic [ADDR_W-1:0] w_addr_rd;
    logic [ADDR_W-1:0] w_addr_wr;
    logic [DATA_W-1:0] w_max;

    assign w_last_pix = (r_row == LAST) && (r_col == LAST);
    assign w_row_rd   = ADDR_W'({r_row, r_k[1]});
    assign w_col_rd   = ADDR_W'({r_col, r_k[0]});
    assign w_addr_rd  = w_row_rd * ADDR_W'(IMG_W) + w_col_rd;
    assign w_addr_wr  = ADDR_W'(r_row) * ADDR_W'(OUT_W) + ADDR_W'(r_col);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        busy     = 1'b0;
        done     = 1'b0;
        crd      = 1'b0;
        cwr      = 1'b0;
        csel     = '0;
        caddr_rd = '0;
        caddr_wr = '0;
        cdata_wr = '0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_next = ST_RD;
                end
            end
            ST_RD: begin
                busy     = 1'b1;
                crd      = ~reset;
                csel     = r_bank ? SRC1_SEL : SRC0_SEL;
                caddr_rd = w_addr_rd;
                if (r_k == 2'd3) begin
                    w_next = ST_WT;
                end
            end
            ST_WT: begin
                busy   = 1'b1;
                csel   = r_bank ? SRC1_SEL : SRC0_SEL;
                w_next = ST_WR;
            end
            ST_WR: begin
                // Strobe is masked by reset so an aborted write never lands
                busy     = 1'b1;
                cwr      = ~reset;
                csel     = r_bank ? DST1_SEL : DST0_SEL;
                caddr_wr = w_addr_wr;
                cdata_wr = w_max;
                w_next   = (w_last_pix && r_bank) ? ST_DONE : ST_RD;
            end
            ST_DONE: begin
                done   = 1'b1;
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // Read data trails the strobe by one cycle, so the compare controls are delayed to match
    always_ff @(posedge clk) begin
        if (reset) begin
            r_row   <= '0;
            r_col   <= '0;
            r_k     <= '0;
            r_bank  <= 1'b0;
            r_vld   <= 1'b0;
            r_first <= 1'b0;
        end else begin
            r_vld   <= (r_state == ST_RD);
            r_first <= (r_state == ST_RD) && (r_k == 2'd0);
            case (r_state)
                ST_IDLE: begin
                    r_row  <= '0;
                    r_col  <= '0;
                    r_k    <= '0;
                    r_bank <= 1'b0;
                end
                ST_RD: begin
                    r_k <= r_k + 2'd1;
                end
                ST_WR: begin
                    if (w_last_pix) begin
                        r_row  <= '0;
                        r_col  <= '0;
                        r_bank <= ~r_bank;
                    end else if (r_col == LAST) begin
                        r_col <= '0;
                        r_row <= r_row + 1'b1;
                    end else begin
                        r_col <= r_col + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    maxpool_cmp4 u_cmp4 (
        .clk    (clk),
        .reset  (reset),
        .i_init (r_first),
        .i_upd  (r_vld),
        .i_data (cdata_rd),
        .o_max  (w_max)
    );

endmodule
